// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder
// Handshaked memory slave for the pipelined MIPS32 core. One shared word array
// serves a read-only instruction port and a load/store data port. Each accepted
// request runs IDLE -> ACCESS (countdown) -> RESP, so exactly one access is in
// flight and a response pulse appears LATENCY edges after the accept edge.
// Ties between the ports are broken round-robin.
// Optional build macro: MIPS32_MEM_ADDR_ERR_EN adds i_err/d_err and rejects any
// captured address with bits above AW set (reads return 0, writes are dropped).
// Without it, those upper address bits are ignored and the address wraps.
module mips32_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_addr,
    output logic        i_resp_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        busy
`ifdef MIPS32_MEM_ADDR_ERR_EN
    ,
    output logic        i_err,
    output logic        d_err
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Countdown start value; unused when LATENCY is 1 (IDLE goes straight to RESP).
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          addr_err_q, addr_err_d;
    logic          i_resp_valid_q, i_resp_valid_d;
    logic          d_resp_valid_q, d_resp_valid_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
`ifdef MIPS32_MEM_ADDR_ERR_EN
    logic          i_err_q, i_err_d;
    logic          d_err_q, d_err_d;
`endif

    logic [31:0]   mem [DEPTH];
    logic          idle;
    logic          i_accept, d_accept;
    logic          i_addr_oor, d_addr_oor;
    logic          mem_we;
    logic [31:0]   resp_word;

`ifdef MIPS32_MEM_ADDR_ERR_EN
    assign i_addr_oor = |i_addr[31:AW];
    assign d_addr_oor = |d_addr[31:AW];
`else
    // Upper address bits are deliberately ignored: addresses alias modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_addr[31:AW], d_addr[31:AW]};
    assign i_addr_oor     = 1'b0;
    assign d_addr_oor     = 1'b0;
`endif

    // Ready/arbitration: only in IDLE; on a tie the port that did not win last time goes.
    assign idle        = (state_q == S_IDLE);
    assign d_req_ready = idle && d_req_valid && (!i_req_valid || (last_grant_q == OWN_I));
    assign i_req_ready = idle && i_req_valid && (!d_req_valid || (last_grant_q == OWN_D));
    assign i_accept    = i_req_ready;
    assign d_accept    = d_req_ready;

    // Next-state logic: capture the request on accept, count down, commit in RESP.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        addr_err_d     = addr_err_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
`ifdef MIPS32_MEM_ADDR_ERR_EN
        i_err_d        = 1'b0;
        d_err_d        = 1'b0;
`endif
        mem_we         = 1'b0;
        resp_word      = mem[addr_q];

        case (state_q)
            S_IDLE: begin
                if (i_accept || d_accept) begin
                    owner_d      = d_accept ? OWN_D : OWN_I;
                    last_grant_d = d_accept ? OWN_D : OWN_I;
                    addr_d       = d_accept ? d_addr[AW-1:0] : i_addr[AW-1:0];
                    we_d         = d_accept && d_we;
                    wdata_d      = d_wdata;
                    addr_err_d   = d_accept ? d_addr_oor : i_addr_oor;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                // A store echoes its data; a rejected address returns zero and never writes.
                if (addr_err_q) begin
                    resp_word = 32'h0;
                end else if (we_q) begin
                    resp_word = wdata_q;
                end
                mem_we = we_q && !addr_err_q;
                if (owner_q == OWN_D) begin
                    d_resp_valid_d = 1'b1;
                    d_rdata_d      = resp_word;
`ifdef MIPS32_MEM_ADDR_ERR_EN
                    d_err_d        = addr_err_q;
`endif
                end else begin
                    i_resp_valid_d = 1'b1;
                    i_rdata_d      = resp_word;
`ifdef MIPS32_MEM_ADDR_ERR_EN
                    i_err_d        = addr_err_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            owner_q        <= OWN_I;
            last_grant_q   <= OWN_I;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= 32'h0;
            addr_err_q     <= 1'b0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_rdata_q      <= 32'h0;
            d_rdata_q      <= 32'h0;
`ifdef MIPS32_MEM_ADDR_ERR_EN
            i_err_q        <= 1'b0;
            d_err_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            addr_err_q     <= addr_err_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
`ifdef MIPS32_MEM_ADDR_ERR_EN
            i_err_q        <= i_err_d;
            d_err_q        <= d_err_d;
`endif
        end
    end

    // Word array write port, committed on the edge that leaves RESP.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst_n.
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign i_resp_valid = i_resp_valid_q;
    assign d_resp_valid = d_resp_valid_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign busy         = !idle;
`ifdef MIPS32_MEM_ADDR_ERR_EN
    assign i_err        = i_err_q;
    assign d_err        = d_err_q;
`endif

endmodule
